ram_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the 256x16 single-port data RAM.
- Port 0 is the CPU load/store path; port 1 is the I/O / debug loader.
- Serialises requests onto the one RAM port with a req/ack handshake.
- Drives registered RAM controls and returns read data per requester, absorbing the block-RAM read latency.

---
 rtl/ram_arb_pkg.sv | 20 ++
 rtl/ram_arbiter_arb_rr2.sv | 29 ++
 rtl/ram_arbiter.sv | 173 +++++++++++++++++
 tb/tb_ram_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared constants for the data-RAM arbiter.
//   - FSM state encodings (IDLE, ISSUE, WAIT, ACK)
//   - requester port indices (P_CPU, P_IO)
//   - default RAM read latency and wait-counter width
package ram_arb_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] ACK   = 2'd3;

    localparam logic P_CPU = 1'b0;
    localparam logic P_IO  = 1'b1;

    localparam int RD_LAT_DEF = 1;

    // Wait counter holds RD_LAT-1, and RD_LAT is at most 4.
    localparam int CNT_W = 2;

endpackage

// File: rtl/ram_arbiter_arb_rr2.sv
// arb_rr2: two-way request picker.
// Ports:
//   req[1:0]    request lines, bit i = port i
//   last_grant  port that won the previous arbitration
//   fixed_prio  1: port 0 always wins a tie; 0: tie goes to the port that
//               did not win last time
//   valid       at least one request is present
//   winner      index of the chosen port (meaningful when valid is high)
module arb_rr2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       fixed_prio,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid  = |req;
        winner = P_CPU;
        if (req == 2'b11) begin
            winner = fixed_prio ? P_CPU : ~last_grant;
        end else if (req[1]) begin
            winner = P_IO;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: serialises two requesters onto one single-port data RAM.
// Port 0 is the CPU load/store path, port 1 the I/O / debug loader.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   reqN/weN/addrN/dinN     request, write select, address, write data (N=0,1)
//   ackN                    one-cycle completion pulse
//   doutN                   read data, valid with ackN, held until the next
//                           read on that port completes
//   gnt                     index of the current or last owner
//   busy                    high whenever the FSM is not IDLE
//   ram_we/ram_addr/ram_din registered RAM controls
//   ram_dout                RAM read data, RD_LAT cycles after ram_addr
//
// Handshake: a requester raises reqN with weN/addrN/dinN stable and holds it
// until ackN pulses; it then drops reqN or presents a new request. A request
// still high when the FSM is back in IDLE is treated as a new request.
//
// Configuration: define ARB_FIXED_PRIO_EN for fixed priority (port 0 wins
// every tie, port 1 may starve); otherwise ties alternate round-robin.
//
// RD_LAT must lie in 1..4.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] din0,
    output logic              ack0,
    output logic [DATA_W-1:0] dout0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] din1,
    output logic              ack1,
    output logic [DATA_W-1:0] dout1,
    output logic              gnt,
    output logic              busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

`ifdef ARB_FIXED_PRIO_EN
    localparam logic FIXED_PRIO = 1'b1;
`else
    localparam logic FIXED_PRIO = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(RD_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              last_grant_q, last_grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_din_q, ram_din_d;
    logic [DATA_W-1:0] dout0_q, dout0_d;
    logic [DATA_W-1:0] dout1_q, dout1_d;

    logic pick_valid;
    logic pick_idx;

    arb_rr2 u_pick (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .fixed_prio (FIXED_PRIO),
        .valid      (pick_valid),
        .winner     (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        ram_we_d     = 1'b0;   // write strobe lives only in ISSUE of a write
        ram_addr_d   = ram_addr_q;
        ram_din_d    = ram_din_q;
        dout0_d      = dout0_q;
        dout1_d      = dout1_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_d        = pick_idx;
                    last_grant_d = pick_idx;
                    state_d      = ISSUE;
                    if (pick_idx == P_IO) begin
                        ram_we_d   = we1;
                        ram_addr_d = addr1;
                        ram_din_d  = din1;
                    end else begin
                        ram_we_d   = we0;
                        ram_addr_d = addr0;
                        ram_din_d  = din0;
                    end
                end
            end
            ISSUE: begin
                // ram_we_q is the registered direction of the granted request.
                if (ram_we_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = LAT_M1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    if (gnt_q == P_IO) begin
                        dout1_d = ram_dout;
                    end else begin
                        dout0_d = ram_dout;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            gnt_q        <= P_CPU;
            last_grant_q <= P_IO;   // so port 0 wins the first tie
            cnt_q        <= '0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_din_q    <= '0;
            dout0_q      <= '0;
            dout1_q      <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_din_q    <= ram_din_d;
            dout0_q      <= dout0_d;
            dout1_q      <= dout1_d;
        end
    end

    assign ack0     = (state_q == ACK) && (gnt_q == P_CPU);
    assign ack1     = (state_q == ACK) && (gnt_q == P_IO);
    assign dout0    = dout0_q;
    assign dout1    = dout1_q;
    assign gnt      = gnt_q;
    assign busy     = (state_q != IDLE);
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed bench for ram_arbiter. Four instances with
// RD_LAT = 1..4 run the same directed sequence side by side, each with its
// own behavioural RAM whose read data appears RD_LAT cycles after ram_addr.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_ram_arbiter;

  localparam int N = 4;

  logic        clk;
  logic        reset;
  logic        req0_v [N];
  logic        req1_v [N];
  logic        we0, we1;
  logic [15:0] addr0, addr1, din0, din1;

  logic        ack0_v [N];
  logic        ack1_v [N];
  logic [15:0] dout0_v [N];
  logic [15:0] dout1_v [N];
  logic        gnt_v [N];
  logic        busy_v [N];
  logic        ram_we_v [N];
  logic [15:0] ram_addr_v [N];
  logic [15:0] ram_din_v [N];
  logic [15:0] ram_dout_v [N];

  int tests;
  int fails;

  // per-transaction observations
  int          ack_cyc [N];
  int          we_cnt [N];
  int          we_cyc [N];
  logic [15:0] we_addr [N];
  logic [15:0] we_din [N];
  logic [15:0] dout_ack [N];
  logic        other_ack [N];
  logic        busy_bad [N];

  // tie-run observations
  int   tie_port [N][4];
  int   tie_cyc [N][4];
  logic tie_gnt [N][4];
  int   tie_n [N];

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs and RAM models ----------------
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int L = g + 1;
    logic [15:0] mem [256];
    logic [15:0] pipe [L];

    ram_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(L)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .req0     (req0_v[g]),
      .we0      (we0),
      .addr0    (addr0),
      .din0     (din0),
      .ack0     (ack0_v[g]),
      .dout0    (dout0_v[g]),
      .req1     (req1_v[g]),
      .we1      (we1),
      .addr1    (addr1),
      .din1     (din1),
      .ack1     (ack1_v[g]),
      .dout1    (dout1_v[g]),
      .gnt      (gnt_v[g]),
      .busy     (busy_v[g]),
      .ram_we   (ram_we_v[g]),
      .ram_addr (ram_addr_v[g]),
      .ram_din  (ram_din_v[g]),
      .ram_dout (ram_dout_v[g])
    );

    initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
      for (int i = 0; i < L; i++) pipe[i] = 16'h0000;
    end

    always @(posedge clk) begin
      if (ram_we_v[g]) mem[ram_addr_v[g][7:0]] <= ram_din_v[g];
      pipe[0] <= mem[ram_addr_v[g][7:0]];
      for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end

    assign ram_dout_v[g] = pipe[L-1];
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic drop_all();
    for (int g = 0; g < N; g++) begin
      req0_v[g] = 1'b0;
      req1_v[g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drop_all();
    repeat (3) step();
    reset = 1'b0;
  endtask

  // One transaction on one port, presented to every instance at once. Each
  // instance's request is dropped in the cycle its ack is seen.
  task automatic txn(input int port, input logic we, input logic [15:0] addr,
                     input logic [15:0] din);
    logic exp_busy, a_p, a_o;
    for (int g = 0; g < N; g++) begin
      ack_cyc[g] = 0; we_cnt[g] = 0; we_cyc[g] = 0; we_addr[g] = '0;
      we_din[g] = '0; dout_ack[g] = '0; other_ack[g] = 1'b0;
      busy_bad[g] = busy_v[g];   // cycle T: still idle
    end
    if (port == 0) begin
      we0 = we; addr0 = addr; din0 = din;
      for (int g = 0; g < N; g++) req0_v[g] = 1'b1;
    end else begin
      we1 = we; addr1 = addr; din1 = din;
      for (int g = 0; g < N; g++) req1_v[g] = 1'b1;
    end
    for (int c = 1; c <= 10; c++) begin
      step();
      for (int g = 0; g < N; g++) begin
        exp_busy = (ack_cyc[g] == 0);
        a_p = (port == 0) ? ack0_v[g] : ack1_v[g];
        a_o = (port == 0) ? ack1_v[g] : ack0_v[g];
        if (busy_v[g] !== exp_busy) busy_bad[g] = 1'b1;
        if (a_o) other_ack[g] = 1'b1;
        if (ram_we_v[g]) begin
          we_cnt[g]++;
          we_cyc[g]  = c;
          we_addr[g] = ram_addr_v[g];
          we_din[g]  = ram_din_v[g];
        end
        if (a_p && ack_cyc[g] == 0) begin
          ack_cyc[g]  = c;
          dout_ack[g] = (port == 0) ? dout0_v[g] : dout1_v[g];
          if (port == 0) req0_v[g] = 1'b0;
          else           req1_v[g] = 1'b0;
        end
      end
    end
    drop_all();
  endtask

  // Both ports read continuously; after four completions on an instance its
  // requests are dropped.
  task automatic tie_run();
    we0 = 1'b0; we1 = 1'b0; addr0 = 16'h0012; addr1 = 16'h0012;
    for (int g = 0; g < N; g++) begin
      tie_n[g] = 0;
      for (int k = 0; k < 4; k++) begin
        tie_port[g][k] = 9; tie_cyc[g][k] = 0; tie_gnt[g][k] = 1'bx;
      end
      req0_v[g] = 1'b1;
      req1_v[g] = 1'b1;
    end
    for (int c = 1; c <= 40; c++) begin
      step();
      for (int g = 0; g < N; g++) begin
        if (tie_n[g] < 4 && (ack0_v[g] || ack1_v[g])) begin
          tie_port[g][tie_n[g]] = ack1_v[g] ? 1 : 0;
          tie_gnt[g][tie_n[g]]  = gnt_v[g];
          tie_cyc[g][tie_n[g]]  = c;
          tie_n[g]++;
          if (tie_n[g] == 4) begin
            req0_v[g] = 1'b0;
            req1_v[g] = 1'b0;
          end
        end
      end
    end
    drop_all();
  endtask

  function automatic int exp_tie_port(input int k);
`ifdef ARB_FIXED_PRIO_EN
    return 0 * k;
`else
    return k % 2;
`endif
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int ack_total;
    tests = 0;
    fails = 0;
    we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; din0 = '0; din1 = '0;
    do_reset();

    // reset values
    for (int g = 0; g < N; g++) begin
      check($sformatf("rst_ack0[%0d]", g),     32'(ack0_v[g]), 32'd0);
      check($sformatf("rst_ack1[%0d]", g),     32'(ack1_v[g]), 32'd0);
      check($sformatf("rst_dout0[%0d]", g),    32'(dout0_v[g]), 32'd0);
      check($sformatf("rst_dout1[%0d]", g),    32'(dout1_v[g]), 32'd0);
      check($sformatf("rst_ram_we[%0d]", g),   32'(ram_we_v[g]), 32'd0);
      check($sformatf("rst_ram_addr[%0d]", g), 32'(ram_addr_v[g]), 32'd0);
      check($sformatf("rst_ram_din[%0d]", g),  32'(ram_din_v[g]), 32'd0);
      check($sformatf("rst_gnt[%0d]", g),      32'(gnt_v[g]), 32'd0);
      check($sformatf("rst_busy[%0d]", g),     32'(busy_v[g]), 32'd0);
    end

    // port-0 write 0x0012 <= 0xBEEF: strobe in T+1 only, ack at T+2
    txn(0, 1'b1, 16'h0012, 16'hBEEF);
    for (int g = 0; g < N; g++) begin
      check($sformatf("wr_ack_cyc[%0d]", g), 32'(ack_cyc[g]), 32'd2);
      check($sformatf("wr_we_cnt[%0d]", g),  32'(we_cnt[g]), 32'd1);
      check($sformatf("wr_we_cyc[%0d]", g),  32'(we_cyc[g]), 32'd1);
      check($sformatf("wr_addr[%0d]", g),    32'(we_addr[g]), 32'h0012);
      check($sformatf("wr_din[%0d]", g),     32'(we_din[g]), 32'hBEEF);
      check($sformatf("wr_ack1[%0d]", g),    32'(other_ack[g]), 32'd0);
      check($sformatf("wr_busy[%0d]", g),    32'(busy_bad[g]), 32'd0);
      check($sformatf("wr_ram_addr_hold[%0d]", g), 32'(ram_addr_v[g]), 32'h0012);
    end

    // port-1 read of 0x0012: ack at T+2+RD_LAT with 0xBEEF, dout0 untouched
    txn(1, 1'b0, 16'h0012, 16'h0000);
    for (int g = 0; g < N; g++) begin
      check($sformatf("rd1_ack_cyc[%0d]", g), 32'(ack_cyc[g]), 32'(g + 3));
      check($sformatf("rd1_dout[%0d]", g),    32'(dout_ack[g]), 32'hBEEF);
      check($sformatf("rd1_dout_hold[%0d]", g), 32'(dout1_v[g]), 32'hBEEF);
      check($sformatf("rd1_dout0[%0d]", g),   32'(dout0_v[g]), 32'd0);
      check($sformatf("rd1_ack0[%0d]", g),    32'(other_ack[g]), 32'd0);
      check($sformatf("rd1_we_cnt[%0d]", g),  32'(we_cnt[g]), 32'd0);
      check($sformatf("rd1_busy[%0d]", g),    32'(busy_bad[g]), 32'd0);
    end

    // simultaneous reads right after reset
    do_reset();
    tie_run();
    for (int g = 0; g < N; g++) begin
      check($sformatf("tie_count[%0d]", g), 32'(tie_n[g]), 32'd4);
      for (int k = 0; k < 4; k++) begin
        check($sformatf("tie_port[%0d][%0d]", g, k), 32'(tie_port[g][k]), 32'(exp_tie_port(k)));
        check($sformatf("tie_gnt[%0d][%0d]", g, k),  32'(tie_gnt[g][k]), 32'(exp_tie_port(k)));
        check($sformatf("tie_cyc[%0d][%0d]", g, k),  32'(tie_cyc[g][k]), 32'((g + 3) + k * (g + 4)));
      end
    end
    step();

    // RD_LAT sweep: preload 0xA5A5 at 0x0040, then read it on port 0
    txn(0, 1'b1, 16'h0040, 16'hA5A5);
    for (int g = 0; g < N; g++) begin
      check($sformatf("pre_ack_cyc[%0d]", g), 32'(ack_cyc[g]), 32'd2);
    end
    txn(0, 1'b0, 16'h0040, 16'h0000);
    for (int g = 0; g < N; g++) begin
      check($sformatf("sw_ack_cyc[%0d]", g), 32'(ack_cyc[g]), 32'(g + 3));
      check($sformatf("sw_dout[%0d]", g),    32'(dout_ack[g]), 32'hA5A5);
      check($sformatf("sw_busy[%0d]", g),    32'(busy_bad[g]), 32'd0);
      check($sformatf("sw_ack1[%0d]", g),    32'(other_ack[g]), 32'd0);
      check($sformatf("sw_dout1[%0d]", g),   32'(dout1_v[g]), 32'hBEEF);
    end

    // reset asserted during WAIT of a read (RD_LAT = 3 instance is index 2)
    we0 = 1'b0; addr0 = 16'h0040;
    for (int g = 0; g < N; g++) req0_v[g] = 1'b1;
    step();                      // T+1: ISSUE
    step();                      // T+2: WAIT, counter = 2
    check("wait_busy", 32'(busy_v[2]), 32'd1);
    check("wait_dout0_pre", 32'(dout0_v[2]), 32'hA5A5);
    reset = 1'b1;
    drop_all();
    step();                      // reset taken on this edge
    check("abort_busy",   32'(busy_v[2]), 32'd0);
    check("abort_ram_we", 32'(ram_we_v[2]), 32'd0);
    check("abort_dout0",  32'(dout0_v[2]), 32'd0);
    check("abort_ack0",   32'(ack0_v[2]), 32'd0);
    reset = 1'b0;
    ack_total = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (ack0_v[2] || ack1_v[2]) ack_total++;
    end
    check("abort_no_ack", 32'(ack_total), 32'd0);
    check("abort_idle",   32'(busy_v[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
